sram_burst_reader: RTL
======================

# sram_burst_reader

Read-side initiator for a single port of the team's multi-port SRAM macro, which has fixed read latency. On a start command it issues sequential word reads from a base address, with wrap-around at `NumWords`. Returned words go into a small response FIFO and leave as a valid/ready stream with a last flag. Credit-based issue ensures no returned word is ever dropped under downstream backpressure, while full one-word-per-cycle throughput is sustained when the consumer is always ready.

## Interface
Parameters:
- `NumWords`, 128: words in the attached SRAM.
- `DataWidth`, 32: SRAM word width.
- `ByteWidth`, 8: SRAM byte width; sets `be_o` width.
- `Latency`, 1: SRAM read latency in cycles. Legal range 1..4.
- `AddrWidth`, derived: `NumWords > 1 ? $clog2(NumWords) : 1`. Do not override.
- `LenWidth`, derived: `$clog2(NumWords+1)`. Do not override.
- `Depth`, derived: `Latency+1`, the response FIFO entries. Do not override.

Ports:
- `clk_i`, in, 1: clock. This is the only clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `start_i`, in, 1: start a burst. Sampled only while idle.
- `base_addr_i`, in, AddrWidth: first word address. Must be < `NumWords`.
- `len_i`, in, LenWidth: number of words, 0..`NumWords`.
- `busy_o`, out, 1: a burst is in progress.
- `done_o`, out, 1: one-cycle pulse at burst completion.
- `req_o`, out, 1: SRAM request.
- `we_o`, out, 1: SRAM write enable, constant 0.
- `addr_o`, out, AddrWidth: SRAM address.
- `wdata_o`, out, DataWidth: constant 0.
- `be_o`, out, ceil(DataWidth/ByteWidth): constant 0.
- `rdata_i`, in, DataWidth: SRAM read data, valid `Latency` cycles after `req_o`.
- `data_o`, out, DataWidth: stream data.
- `valid_o`, out, 1: stream valid.
- `ready_i`, in, 1: stream ready.
- `last_o`, out, 1: final beat of the burst. Qualified by `valid_o`.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
- IDLE to ISSUE: `start_i` high and `len_i` != 0. The block latches the address and length.
- IDLE with `start_i` high and `len_i` == 0: the block issues no request and pulses `done_o` in the next cycle.
- ISSUE: each cycle, `req_o` = 1 when `credits` < `Depth`, or when `credits` == `Depth` and a beat is popped this cycle.
  - `credits` = in-flight reads + FIFO occupancy.
  - On each issue, the address increments; it wraps from `NumWords-1` to 0. The remaining count decrements.
  - After the final issue the FSM moves to DRAIN.
- DRAIN to IDLE: on the handshake (`valid_o && ready_i`) of the beat with `last_o`.
- In-flight tracking uses a `Latency`-deep valid shift register. Its tail pushes `rdata_i` into the FIFO.
- `last_o` is carried as a FIFO sideband bit, set on the word from the final issue.
- `start_i` is ignored while busy.
- The FIFO never overflows. Verification asserts that a push never occurs when the FIFO is full.
- `valid_o`, `data_o` and `last_o` stay stable while `valid_o && !ready_i`.
- Reset mid-burst clears FSM, counters, shift register and FIFO. SRAM data returning after reset is discarded.

## Timing
- Reset values:
  - `busy_o`, `done_o`, `req_o`, `valid_o`, `last_o`: 0.
  - `addr_o`, `data_o`: 0.
  - `we_o`, `wdata_o`, `be_o`: 0 at all times.
- Start is accepted at clock edge 0. The first `req_o` is in cycle 1. `rdata_i` is captured at the end of cycle 1+`Latency`, and the first `valid_o` is in cycle 2+`Latency`.
- `busy_o` is high from cycle 1 through the cycle of the last handshake.
- `done_o` is high the following cycle, with `busy_o` low. A new start is accepted in that cycle.
- With `ready_i` held high, a burst of N words completes its last handshake in cycle N+1+`Latency`.
- Outputs are register-driven, with no combinational path from `ready_i` to `req_o` other than the pop-credit term.

## Structure
- `sram_burst_reader_pkg` holds the FSM state enum. Width helpers stay local to the module.
- Sub-module `sram_rsp_fifo` is a parameterised register FIFO, `Depth` entries deep and DataWidth+1 bits wide, with full/empty/count outputs.

## Test plan
1. `Latency`=1, base 5, len 4, `ready_i`=1:
   - Addresses 5,6,7,8 on consecutive cycles.
   - 4 beats, last on beat 4.
   - `done_o` in cycle 7.
2. `NumWords`=128, base 126, len 4: addresses 126,127,0,1, data in that order.
3. `Latency`=3, len 16, `ready_i` toggling 1/0 randomly:
   - All 16 words delivered in order, none lost.
   - In-flight + occupancy ≤ 4 at all times.
   - Data held stable while stalled.
4. len 0: no `req_o`, `done_o` pulse one cycle after start, `busy_o` never high.
5. `rst_i` asserted during DRAIN with 2 words in flight: all outputs 0 next cycle, no beats after release, a new burst runs correctly.
6. `start_i` pulsed mid-burst with a different base: ignored, original burst completes unchanged.

Source files
------------

// File: rtl/sram_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_reader_pkg
// Brief    : Shared types for the SRAM burst reader (FSM state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package sram_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_rsp_fifo
// Brief    : Register-based response FIFO with full/empty/count status.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wptr;
    logic [C_PTR_W-1:0] r_rptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (r_count == C_CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata_i;
                r_wptr        <= f_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_reader
// Brief    : Credit-paced sequential SRAM burst reader with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module sram_burst_reader
    import sram_burst_reader_pkg::*;
#(
    parameter int NumWords  = 128,
    parameter int DataWidth = 32,
    parameter int ByteWidth = 8,
    parameter int Latency   = 1,
    parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int LenWidth  = $clog2(NumWords + 1),
    parameter int Depth     = Latency + 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       start_i,
    input  logic [AddrWidth-1:0]                       base_addr_i,
    input  logic [LenWidth-1:0]                        len_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       req_o,
    output logic                                       we_o,
    output logic [AddrWidth-1:0]                       addr_o,
    output logic [DataWidth-1:0]                       wdata_o,
    output logic [(DataWidth+ByteWidth-1)/ByteWidth-1:0] be_o,
    input  logic [DataWidth-1:0]                       rdata_i,
    output logic [DataWidth-1:0]                       data_o,
    output logic                                       valid_o,
    input  logic                                       ready_i,
    output logic                                       last_o
);

    localparam int                   C_CRED_W   = $clog2(Depth + 1);
    localparam logic [AddrWidth-1:0] C_ADDR_MAX = AddrWidth'(NumWords - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [AddrWidth-1:0]  r_addr;
    logic [LenWidth-1:0]   r_remain;
    logic [Latency-1:0]    r_vld_sr;
    logic [Latency-1:0]    r_last_sr;
    logic                  r_done;

    logic                  w_issue;
    logic                  w_final_issue;
    logic                  w_start_ok;
    logic                  w_start_empty;
    logic                  w_pop;
    logic                  w_last_pop;
    logic                  w_push;
    logic                  w_can_issue;
    logic [C_CRED_W-1:0]   w_inflight;
    logic [C_CRED_W-1:0]   w_credits;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [C_CRED_W-1:0]   w_fifo_count;
    logic [DataWidth:0]    w_fifo_rdata;

    assign we_o    = 1'b0;
    assign wdata_o = '0;
    assign be_o    = '0;
    assign addr_o  = r_addr;
    assign done_o  = r_done;
    assign req_o   = w_issue;

    assign valid_o    = !w_fifo_empty;
    assign data_o     = w_fifo_rdata[DataWidth-1:0];
    assign last_o     = valid_o && w_fifo_rdata[DataWidth];
    assign w_pop      = valid_o && ready_i;
    assign w_last_pop = w_pop && last_o;

    assign w_start_ok    = (r_state == ST_IDLE) && start_i && (len_i != '0);
    assign w_start_empty = (r_state == ST_IDLE) && start_i && (len_i == '0);
    assign w_final_issue = w_issue && (r_remain == LenWidth'(1));

    // A credit is any word issued but not yet handed downstream; a pop in the
    // same cycle frees one, which keeps back-to-back issue with ready held high.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < Latency; i++) begin
            w_inflight = w_inflight + C_CRED_W'(r_vld_sr[i]);
        end
        w_credits   = w_inflight + w_fifo_count;
        w_can_issue = (w_credits < C_CRED_W'(Depth)) ||
                      ((w_credits == C_CRED_W'(Depth)) && w_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok)    w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_final_issue) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_pop)    w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (r_state != ST_IDLE);
        w_issue = (r_state == ST_ISSUE) && w_can_issue;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_start_empty || ((r_state == ST_DRAIN) && w_last_pop);
            if (w_start_ok) begin
                r_addr   <= base_addr_i;
                r_remain <= len_i;
            end else if (w_issue) begin
                r_addr   <= (r_addr == C_ADDR_MAX) ? '0 : r_addr + 1'b1;
                r_remain <= r_remain - 1'b1;
            end
        end
    end

    // Tracks which SRAM return slots carry our data; cleared on reset so
    // reads still in flight at that point are never captured.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_sr  <= '0;
            r_last_sr <= '0;
        end else begin
            r_vld_sr[0]  <= w_issue;
            r_last_sr[0] <= w_final_issue;
            for (int i = 1; i < Latency; i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1];
                r_last_sr[i] <= r_last_sr[i-1];
            end
        end
    end

    assign w_push = r_vld_sr[Latency-1] && !w_fifo_full;

    sram_rsp_fifo #(
        .DEPTH (Depth),
        .WIDTH (DataWidth + 1)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .wdata_i ({r_last_sr[Latency-1], rdata_i}),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

endmodule
`default_nettype wire
